// File: rtl/serializer_pkg.sv
// Shared state type, counter sizing helper and width ceiling for the parametrised serializer.
package serializer_pkg;

    localparam int SER_MAX_WIDTH = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Wide enough to hold every position of a frame, parity bit included.
    function automatic int ser_cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Frame bit counter: clear restarts at 0, enable advances and wraps after position FL-1.
// Latency: count and last are registered and update on the edge that sees clear/enable.
// Backpressure: none of its own; enable low holds count and last indefinitely.
module ser_bit_counter
    import serializer_pkg::*;
#(
    parameter int FL    = 8,
    parameter int CNT_W = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(FL - 1);

    logic [CNT_W-1:0] count_q;

    // last is registered alongside the count so it lines up with the bit it marks.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
            last    <= 1'b0;
        end else if (clear) begin
            count_q <= '0;
            last    <= (TERM == '0);
        end else if (enable) begin
            if (count_q == TERM) begin
                count_q <= '0;
                last    <= 1'b0;
            end else begin
                count_q <= count_q + 1'b1;
                last    <= ((count_q + 1'b1) == TERM);
            end
        end
    end

endmodule

// File: rtl/param_serializer.sv
// Parallel word to serial bit stream with optional trailing parity bit (SERIALIZE_PARITY_EN).
// Latency: first bit valid from the load edge; back-to-back frames run with no idle gap.
// Backpressure: ser_ready low holds the current bit; load_ready opens only when idle or on a consumed last bit.
module param_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LSB_FIRST  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);

    if (WIDTH < 2 || WIDTH > SER_MAX_WIDTH || LSB_FIRST < 0 || LSB_FIRST > 1 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("param_serializer: illegal parameter set");
    end

`ifdef SERIALIZE_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif
    localparam int CNT_W = ser_cnt_w(WIDTH);

    ser_state_t    state_q;
    logic [FL-1:0] sreg_q;
    logic [FL-1:0] sreg_shift;
    logic [FL-1:0] load_word;
    logic          load_fire;
    logic          bit_fire;

    function automatic logic head_bit(input logic [FL-1:0] v);
        return (LSB_FIRST != 0) ? v[0] : v[FL-1];
    endfunction

    // Parity rides at the far end of the register so it leaves after the data bits.
`ifdef SERIALIZE_PARITY_EN
    logic par_bit;
    assign par_bit   = (^load_data) ^ (PARITY_ODD != 0);
    assign load_word = (LSB_FIRST != 0) ? {par_bit, load_data} : {load_data, par_bit};
`else
    assign load_word = load_data;
`endif

    assign sreg_shift = (LSB_FIRST != 0) ? (sreg_q >> 1) : (sreg_q << 1);
    assign ser_out    = head_bit(sreg_q);
    assign bit_fire   = ser_valid && ser_ready;
    assign load_ready = reset_n && ((state_q == IDLE) || (ser_last && ser_ready));
    assign load_fire  = load_valid && load_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (load_fire) begin
            state_q   <= SHIFT;
            sreg_q    <= load_word;
            ser_valid <= 1'b1;
            busy      <= 1'b1;
        end else if (bit_fire) begin
            sreg_q <= sreg_shift;
            if (ser_last) begin
                state_q   <= IDLE;
                ser_valid <= 1'b0;
                busy      <= 1'b0;
            end
        end
    end

    ser_bit_counter #(
        .FL   (FL),
        .CNT_W(CNT_W)
    ) u_bit_counter (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (load_fire),
        .enable (bit_fire),
        .last   (ser_last)
    );

endmodule
